// File: rtl/mio_pkg.sv
// Shared types and constants for the memory/IO bus responder.
package mio_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RAM_ACC = 2'd1,
    IO_ACC  = 2'd2,
    DONE    = 2'd3
  } mio_state_t;

  localparam logic [3:0]  IO_NIB_E     = 4'hE;
  localparam logic [3:0]  IO_NIB_F     = 4'hF;
  localparam logic [31:0] TIMEOUT_FILL = 32'hDEAD_BEEF;

  // The top nibble of the byte address selects the peripheral region.
  function automatic logic is_io_nib(input logic [3:0] nib);
    return (nib == IO_NIB_E) || (nib == IO_NIB_F);
  endfunction

endpackage

// File: rtl/mio_wait_cnt.sv
// 4-bit load/decrement counter with a terminal flag, shared by RAM wait states and IO timeout.
module mio_wait_cnt
  import mio_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       term
);

  logic [3:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 4'd0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != 4'd0)) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign term = (cnt_q == 4'd0);

endmodule

// File: rtl/mio_bus_responder.sv
// Memory/IO bus responder: one word access at a time to on-chip RAM or the peripheral region.
// Define MIO_TIMEOUT_EN to force completion of IO accesses that never see io_ack.
module mio_bus_responder
  import mio_pkg::*;
#(
  parameter int RAM_WAIT   = 1,
  parameter int RAM_ADDR_W = 10,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_r,
  input  logic                  mem_w,
  input  logic [31:0]           addr,
  input  logic [31:0]           data_to_mio,
  output logic [31:0]           data_from_mio,
  output logic                  mio_ready,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic                  ram_we,
  output logic [31:0]           ram_din,
  input  logic [31:0]           ram_dout,
  output logic [31:0]           io_addr,
  output logic                  io_rd,
  output logic                  io_wr,
  output logic [31:0]           io_din,
  input  logic [31:0]           io_dout,
  input  logic                  io_ack,
  output logic                  bus_err
);

  localparam logic [3:0] RAM_LOAD = 4'(RAM_WAIT - 1);
  localparam logic [3:0] IO_LOAD  = 4'(TIMEOUT - 1);

  mio_state_t  state_q, state_nxt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        wr_q;
  logic        ram_we_q;
  logic        req_io;
  logic        accept;
  logic        cnt_load;
  logic        cnt_dec;
  logic [3:0]  cnt_load_val;
  logic        cnt_term;
  logic        cap_ram;
  logic        cap_io;
`ifdef MIO_TIMEOUT_EN
  logic        cap_to;
  logic        bus_err_q;
`endif

  assign req_io       = is_io_nib(addr[31:28]);
  assign cnt_load_val = req_io ? IO_LOAD : RAM_LOAD;

  mio_wait_cnt u_wait_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .term     (cnt_term)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    accept    = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cap_ram   = 1'b0;
    cap_io    = 1'b0;
    mio_ready = 1'b0;
    io_rd     = 1'b0;
    io_wr     = 1'b0;
`ifdef MIO_TIMEOUT_EN
    cap_to    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (mem_r || mem_w) begin
          accept    = 1'b1;
          cnt_load  = 1'b1;
          state_nxt = req_io ? IO_ACC : RAM_ACC;
        end
      end
      RAM_ACC: begin
        if (cnt_term) begin
          cap_ram   = !wr_q;
          state_nxt = DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      IO_ACC: begin
        // Strobes are decoded from state so they fall on the edge that samples the ack.
        io_rd   = !wr_q;
        io_wr   = wr_q;
        cnt_dec = 1'b1;
        if (io_ack) begin
          cap_io    = !wr_q;
          state_nxt = DONE;
`ifdef MIO_TIMEOUT_EN
        end else if (cnt_term) begin
          cap_to    = 1'b1;
          state_nxt = DONE;
`endif
        end
      end
      DONE: begin
        mio_ready = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, RAM write strobe and read-data register.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q        <= 32'd0;
      wdata_q       <= 32'd0;
      wr_q          <= 1'b0;
      ram_we_q      <= 1'b0;
      data_from_mio <= 32'd0;
    end else begin
      if (accept) begin
        addr_q   <= addr;
        wdata_q  <= data_to_mio;
        wr_q     <= mem_w;
        ram_we_q <= mem_w && !req_io;
      end else begin
        ram_we_q <= 1'b0;
      end
      if (cap_ram) begin
        data_from_mio <= ram_dout;
      end else if (cap_io) begin
        data_from_mio <= io_dout;
`ifdef MIO_TIMEOUT_EN
      end else if (cap_to && !wr_q) begin
        data_from_mio <= TIMEOUT_FILL;
`endif
      end
    end
  end

`ifdef MIO_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_err_q <= 1'b0;
    end else if (cap_to) begin
      bus_err_q <= 1'b1;
    end
  end
  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

  assign ram_addr = addr_q[RAM_ADDR_W+1:2];
  assign ram_we   = ram_we_q;
  assign ram_din  = wdata_q;
  assign io_addr  = addr_q;
  assign io_din   = wdata_q;

endmodule
